// File: rtl/orbtrace_sync_pkg.sv
// Shared definitions for the multi-channel asynchronous event capture block:
// edge-mode encodings, counter saturation and arm-delay helpers.
package orbtrace_sync_pkg;

  typedef enum logic [1:0] {
    EDGE_BOTH = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_mode_e;

  localparam int MAX_CNT_W = 32;

  function automatic logic [MAX_CNT_W-1:0] cnt_max(input int width);
    if (width >= MAX_CNT_W) return '1;
    return (MAX_CNT_W'(1) << width) - MAX_CNT_W'(1);
  endfunction

  // True when a counter of the given width sits at all-ones and must hold.
  function automatic logic cnt_saturated(input logic [MAX_CNT_W-1:0] value,
                                         input int width);
    return value == cnt_max(width);
  endfunction

  // Cycles after reset release before channels take their first level.
  function automatic int arm_delay(input int stages, input int filter_len);
    return stages + filter_len;
  endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// One capture channel: synchroniser, run-length glitch filter, edge decode
// and saturating event counter with read-and-clear.
module sync_filter_chan
  import orbtrace_sync_pkg::*;
#(
  parameter int STAGES     = 2,
  parameter int FILTER_LEN = 3,
  parameter int CNT_W      = 8,
  parameter int EDGE_MODE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             async_i,
  input  logic             sample_i,
  input  logic             armed_i,
  input  logic             clr_i,
  output logic             level_o,
  output logic             pulse_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  localparam int RUN_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILTER_LEN - 1);
  localparam logic RISE_EN = (EDGE_MODE != int'(EDGE_FALL));
  localparam logic FALL_EN = (EDGE_MODE != int'(EDGE_RISE));

  logic [STAGES-1:0] sync_q, sync_d;
  logic              sync_bit;
  logic              level_q, level_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              pulse_q, pulse_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              sat;

  assign sync_d   = {sync_q[STAGES-2:0], async_i};
  assign sync_bit = sync_q[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      run_q   <= '0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      run_q   <= run_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // The arming load takes the synchronised level silently, so an input that
  // was already high during reset never looks like an edge.
  always_comb begin
    level_d = level_q;
    run_d   = '0;
    pulse_d = 1'b0;
    if (sample_i) begin
      level_d = sync_bit;
    end else if (armed_i && (sync_bit != level_q)) begin
      if (run_q == RUN_LAST) begin
        level_d = sync_bit;
        pulse_d = sync_bit ? RISE_EN : FALL_EN;
      end else begin
        run_d = run_q + RUN_W'(1);
      end
    end
  end

  assign sat = cnt_saturated(MAX_CNT_W'(cnt_q), CNT_W);

  // A pulse coinciding with a clear belongs to the new counting period.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = pulse_q ? CNT_W'(1) : '0;
      ovf_d = 1'b0;
    end else if (pulse_q) begin
      if (sat) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;
  assign cnt_o   = cnt_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/multi_event_sync.sv
// N-channel receiver for foreign-domain level/toggle flags: per-channel
// capture pipelines plus a shared arm sequencer and read-and-clear port.
module multi_event_sync
  import orbtrace_sync_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int STAGES     = 2,
  parameter int FILTER_LEN = 3,
  parameter int CNT_W      = 8,
  parameter int EDGE_MODE  = 0,
  localparam int CHAN_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] async_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] event_pulse,
  input  logic                rd_req,
  input  logic [CHAN_W-1:0]   rd_chan,
  output logic                rd_valid,
  output logic [CNT_W-1:0]    rd_data,
  output logic                rd_ovf
);

  localparam int ARM_DELAY = arm_delay(STAGES, FILTER_LEN);
  localparam int ARM_W     = $clog2(ARM_DELAY);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_DELAY - 1);

  logic [ARM_W-1:0]    arm_cnt_q, arm_cnt_d;
  logic                armed_q, armed_d;
  logic                arm_load;

  logic [CNT_W-1:0]    cnt_arr [CHANNELS];
  logic [CHANNELS-1:0] ovf_vec;
  logic [CHANNELS-1:0] clr_vec;

  logic [CNT_W-1:0]    sel_cnt;
  logic                sel_ovf;
  logic                rd_valid_q;
  logic [CNT_W-1:0]    rd_data_q, rd_data_d;
  logic                rd_ovf_q, rd_ovf_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      arm_cnt_q <= '0;
      armed_q   <= 1'b0;
    end else begin
      arm_cnt_q <= arm_cnt_d;
      armed_q   <= armed_d;
    end
  end

  always_comb begin
    arm_cnt_d = arm_cnt_q;
    armed_d   = armed_q;
    arm_load  = 1'b0;
    if (!armed_q) begin
      if (arm_cnt_q == ARM_LAST) begin
        armed_d  = 1'b1;
        arm_load = 1'b1;
      end else begin
        arm_cnt_d = arm_cnt_q + ARM_W'(1);
      end
    end
  end

  // An out-of-range rd_chan matches no channel: nothing clears, reply is 0/0.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    assign clr_vec[gi] = rd_req & (rd_chan == CHAN_W'(gi));

    sync_filter_chan #(
      .STAGES     (STAGES),
      .FILTER_LEN (FILTER_LEN),
      .CNT_W      (CNT_W),
      .EDGE_MODE  (EDGE_MODE)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .async_i  (async_in[gi]),
      .sample_i (arm_load),
      .armed_i  (armed_q),
      .clr_i    (clr_vec[gi]),
      .level_o  (level_out[gi]),
      .pulse_o  (event_pulse[gi]),
      .cnt_o    (cnt_arr[gi]),
      .ovf_o    (ovf_vec[gi])
    );
  end

  always_comb begin
    sel_cnt = '0;
    sel_ovf = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (clr_vec[i]) begin
        sel_cnt = cnt_arr[i];
        sel_ovf = ovf_vec[i];
      end
    end
    rd_data_d = rd_data_q;
    rd_ovf_d  = rd_ovf_q;
    if (rd_req) begin
      rd_data_d = sel_cnt;
      rd_ovf_d  = sel_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_ovf_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_req;
      rd_data_q  <= rd_data_d;
      rd_ovf_q   <= rd_ovf_d;
    end
  end

  // Masking with rst drops a response still pending when reset arrives.
  assign rd_valid = rd_valid_q & ~rst;
  assign rd_data  = rd_data_q;
  assign rd_ovf   = rd_ovf_q;

endmodule

// File: tb/tb_multi_event_sync.sv
// Directed bench for multi_event_sync: three instances (both/rise/fall edge
// modes) share one stimulus; read responses are checked from a scoreboard.
module tb_multi_event_sync;

  localparam int STAGES     = 2;
  localparam int FILTER_LEN = 3;
  localparam int ARM        = STAGES + FILTER_LEN;
  localparam int CNT_MAX    = 15;

  typedef struct packed {
    logic [2:0][3:0] data;
    logic [2:0]      ovf;
    logic [3:0]      chan;
  } resp_t;

  logic       clk;
  logic       rst;
  logic [3:0] async_in;
  logic       rd_req;
  logic [1:0] rd_chan;

  logic [3:0] main_level, main_pulse, main_rd_data;
  logic       main_rd_valid, main_rd_ovf;
  logic [2:0] rise_level, rise_pulse, fall_level, fall_pulse;
  logic [3:0] rise_rd_data, fall_rd_data;
  logic       rise_rd_valid, rise_rd_ovf, fall_rd_valid, fall_rd_ovf;

  int    checks = 0;
  int    errors = 0;
  resp_t exp_q[$];
  int    exp_cnt [3][4];
  bit    exp_ovf [3][4];

  multi_event_sync #(.CHANNELS(4), .STAGES(STAGES), .FILTER_LEN(FILTER_LEN),
                     .CNT_W(4), .EDGE_MODE(0)) u_main (
    .clk(clk), .rst(rst), .async_in(async_in),
    .level_out(main_level), .event_pulse(main_pulse),
    .rd_req(rd_req), .rd_chan(rd_chan), .rd_valid(main_rd_valid),
    .rd_data(main_rd_data), .rd_ovf(main_rd_ovf)
  );

  multi_event_sync #(.CHANNELS(3), .STAGES(STAGES), .FILTER_LEN(FILTER_LEN),
                     .CNT_W(4), .EDGE_MODE(1)) u_rise (
    .clk(clk), .rst(rst), .async_in(async_in[2:0]),
    .level_out(rise_level), .event_pulse(rise_pulse),
    .rd_req(rd_req), .rd_chan(rd_chan), .rd_valid(rise_rd_valid),
    .rd_data(rise_rd_data), .rd_ovf(rise_rd_ovf)
  );

  multi_event_sync #(.CHANNELS(3), .STAGES(STAGES), .FILTER_LEN(FILTER_LEN),
                     .CNT_W(4), .EDGE_MODE(2)) u_fall (
    .clk(clk), .rst(rst), .async_in(async_in[2:0]),
    .level_out(fall_level), .event_pulse(fall_pulse),
    .rd_req(rd_req), .rd_chan(rd_chan), .rd_valid(fall_rd_valid),
    .rd_data(fall_rd_data), .rd_ovf(fall_rd_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int nch(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  task automatic bump(input int d, input int ch);
    if (ch < nch(d)) begin
      if (exp_cnt[d][ch] == CNT_MAX) exp_ovf[d][ch] = 1'b1;
      else exp_cnt[d][ch]++;
    end
  endtask

  task automatic model_edge(input int ch, input logic rising);
    bump(0, ch);
    if (rising) bump(1, ch);
    else bump(2, ch);
  endtask

  task automatic model_clear_all();
    for (int d = 0; d < 3; d++)
      for (int ch = 0; ch < 4; ch++) begin
        exp_cnt[d][ch] = 0;
        exp_ovf[d][ch] = 1'b0;
      end
  endtask

  // Advance to the next falling edge and check any read response due there.
  task automatic tick();
    resp_t r;
    bit    expv;
    @(negedge clk);
    expv = (exp_q.size() != 0);
    chk("rd_valid main", 32'(main_rd_valid), 32'(expv));
    chk("rd_valid rise", 32'(rise_rd_valid), 32'(expv));
    chk("rd_valid fall", 32'(fall_rd_valid), 32'(expv));
    if (expv) begin
      r = exp_q.pop_front();
      $display("rd ch%0d: main %0d/%0d rise %0d/%0d fall %0d/%0d", r.chan,
               main_rd_data, main_rd_ovf, rise_rd_data, rise_rd_ovf,
               fall_rd_data, fall_rd_ovf);
      chk($sformatf("rd_data main ch%0d", r.chan), 32'(main_rd_data), 32'(r.data[0]));
      chk($sformatf("rd_ovf main ch%0d", r.chan), 32'(main_rd_ovf), 32'(r.ovf[0]));
      chk($sformatf("rd_data rise ch%0d", r.chan), 32'(rise_rd_data), 32'(r.data[1]));
      chk($sformatf("rd_ovf rise ch%0d", r.chan), 32'(rise_rd_ovf), 32'(r.ovf[1]));
      chk($sformatf("rd_data fall ch%0d", r.chan), 32'(fall_rd_data), 32'(r.data[2]));
      chk($sformatf("rd_ovf fall ch%0d", r.chan), 32'(fall_rd_ovf), 32'(r.ovf[2]));
    end
  endtask

  function automatic resp_t make_resp(input int ch);
    resp_t r;
    r      = '0;
    r.chan = 4'(ch);
    for (int d = 0; d < 3; d++) begin
      if (ch < nch(d)) begin
        r.data[d] = 4'(exp_cnt[d][ch]);
        r.ovf[d]  = exp_ovf[d][ch];
      end
    end
    return r;
  endfunction

  task automatic read(input int ch);
    exp_q.push_back(make_resp(ch));
    for (int d = 0; d < 3; d++) begin
      if (ch < nch(d)) begin
        exp_cnt[d][ch] = 0;
        exp_ovf[d][ch] = 1'b0;
      end
    end
    rd_req  = 1'b1;
    rd_chan = 2'(ch);
    tick();
    rd_req  = 1'b0;
  endtask

  task automatic set_in(input logic [3:0] v, input int hold);
    for (int ch = 0; ch < 4; ch++)
      if (v[ch] != async_in[ch]) model_edge(ch, v[ch]);
    async_in = v;
    repeat (hold) tick();
  endtask

  initial begin
    rst      = 1'b1;
    async_in = 4'b1111;
    rd_req   = 1'b0;
    rd_chan  = 2'd0;
    model_clear_all();
    repeat (5) tick();

    chk("reset level_out main", 32'(main_level), 32'h0);
    chk("reset event_pulse main", 32'(main_pulse), 32'h0);
    chk("reset rd_data main", 32'(main_rd_data), 32'h0);
    chk("reset rd_ovf main", 32'(main_rd_ovf), 32'h0);
    chk("reset level_out rise", 32'(rise_level), 32'h0);
    chk("reset level_out fall", 32'(fall_level), 32'h0);

    // Release with inputs high; an unarmed read answers zeros.
    rst = 1'b0;
    read(1);
    for (int k = 2; k < ARM; k++) begin
      tick();
      chk($sformatf("pre-arm level_out k%0d", k), 32'(main_level), 32'h0);
      chk($sformatf("pre-arm event_pulse k%0d", k), 32'(main_pulse), 32'h0);
    end
    tick();
    chk("arm level_out main", 32'(main_level), 32'hf);
    chk("arm level_out rise", 32'(rise_level), 32'h7);
    chk("arm level_out fall", 32'(fall_level), 32'h7);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("post-arm no pulse main", 32'(main_pulse), 32'h0);
      chk("post-arm no pulse rise", 32'(rise_pulse), 32'h0);
      chk("post-arm no pulse fall", 32'(fall_pulse), 32'h0);
    end

    set_in(4'b0000, 10);

    // Clean rise on ch0: pulse exactly STAGES+FILTER_LEN cycles later.
    async_in = 4'b0001;
    model_edge(0, 1'b1);
    for (int k = 1; k < ARM; k++) begin
      tick();
      chk($sformatf("latency early k%0d", k), 32'(main_pulse[0]), 32'h0);
    end
    tick();
    chk("latency pulse main", 32'(main_pulse[0]), 32'h1);
    chk("latency pulse rise", 32'(rise_pulse[0]), 32'h1);
    chk("latency pulse fall", 32'(fall_pulse[0]), 32'h0);
    chk("latency level main", 32'(main_level), 32'h1);
    tick();
    chk("latency pulse width", 32'(main_pulse[0]), 32'h0);
    repeat (4) tick();

    // Two-cycle glitch on ch1 must be rejected.
    async_in = 4'b0011;
    tick();
    tick();
    async_in = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("glitch level main", 32'(main_level), 32'h1);
      chk("glitch pulse main", 32'(main_pulse), 32'h0);
      chk("glitch pulse rise", 32'(rise_pulse), 32'h0);
    end

    // Edge modes: three rise/fall pairs on ch2.
    read(2);
    for (int p = 0; p < 3; p++) begin
      set_in(4'b0101, 8);
      set_in(4'b0001, 8);
    end
    read(2);
    read(0);
    read(1);
    tick();

    // Saturation on ch3; the 3-channel instances see ch3 as out of range.
    for (int p = 0; p < 10; p++) begin
      set_in(4'b1001, 6);
      set_in(4'b0001, 6);
    end
    tick();
    read(3);
    read(3);
    tick();

    // Seven events on ch0, then read exactly when the eighth pulse shows.
    for (int p = 0; p < 7; p++) set_in((p % 2 == 0) ? 4'b0000 : 4'b0001, 8);
    async_in = 4'b0001;
    repeat (ARM) tick();
    chk("coincident pulse main", 32'(main_pulse[0]), 32'h1);
    read(0);
    bump(0, 0);
    bump(1, 0);
    repeat (3) tick();
    read(0);
    tick();

    // Reset arriving the cycle after a read drops its response.
    set_in(4'b0011, 8);
    rd_req  = 1'b1;
    rd_chan = 2'd1;
    @(posedge clk);
    #1;
    rst    = 1'b1;
    rd_req = 1'b0;
    exp_q.delete();
    model_clear_all();
    tick();
    chk("reset drops rd_valid", 32'(main_rd_valid), 32'h0);
    async_in = 4'b0000;
    repeat (3) tick();
    rst = 1'b0;
    repeat (ARM + 4) tick();
    chk("re-arm level_out main", 32'(main_level), 32'h0);
    for (int ch = 0; ch < 4; ch++) read(ch);
    tick();
    chk("scoreboard drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
